// File: rtl/ovl_fire_collector.sv
// Collects 3-bit OVL checker fire vectors, timestamps them, queues one record per
// firing on a valid/ready drain port, and keeps saturating per-type statistics.
module ovl_fire_collector #(
  parameter int NUM_CHK    = 4,
  parameter int TS_W       = 32,
  parameter int CNT_W      = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clock_i,
  input  logic                          reset_ni,
  input  logic                          enable_i,
  input  logic                          clear_i,
  input  logic [3*NUM_CHK-1:0]          fire_i,
  output logic                          evt_valid_o,
  input  logic                          evt_ready_i,
  output logic [$clog2(NUM_CHK)-1:0]    evt_id_o,
  output logic [2:0]                    evt_type_o,
  output logic [TS_W-1:0]               evt_ts_o,
  output logic [CNT_W-1:0]              fail_cnt_o,
  output logic [CNT_W-1:0]              xchk_cnt_o,
  output logic [CNT_W-1:0]              cover_cnt_o,
  output logic [CNT_W-1:0]              coal_cnt_o,
  output logic                          fail_seen_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int IDW   = $clog2(NUM_CHK);
  localparam int PW    = $clog2(FIFO_DEPTH);
  localparam int LW    = PW + 1;
  localparam int IW    = $clog2(NUM_CHK + 1);
  localparam int REC_W = IDW + 3 + TS_W;

  logic [TS_W-1:0]    ts_q;
  logic [NUM_CHK-1:0] pend_q, pend_d;
  logic [2:0]         ptype_q [NUM_CHK];
  logic [2:0]         ptype_d [NUM_CHK];
  logic [TS_W-1:0]    pts_q   [NUM_CHK];
  logic [TS_W-1:0]    pts_d   [NUM_CHK];
  logic [IDW-1:0]     rr_q, rr_d;
  logic [REC_W-1:0]   mem_q   [FIFO_DEPTH];
  logic [PW-1:0]      wr_q, rd_q;
  logic [LW-1:0]      level_q, level_d;
  logic [CNT_W-1:0]   fail_q, xchk_q, cover_q, coal_q;
  logic               fail_seen_q;

  logic [3*NUM_CHK-1:0] fire_c;
  logic                 pop, push, gnt_vld;
  logic [IDW-1:0]       gnt_idx;
  logic [IW-1:0]        fail_inc, xchk_inc, cover_inc, coal_inc;
  logic [REC_W-1:0]     push_rec, head;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [IW-1:0]    b);
    logic [CNT_W+IW-1:0] s;
    s = {{IW{1'b0}}, a} + {{CNT_W{1'b0}}, b};
    if (s > {{IW{1'b0}}, {CNT_W{1'b1}}}) return '1;
    return s[CNT_W-1:0];
  endfunction

  // An unknown fire bit takes the else branch in simulation, so X never opens a record.
  always_comb begin
    fire_c = '0;
    for (int b = 0; b < 3*NUM_CHK; b++) begin
      if (fire_i[b]) fire_c[b] = 1'b1;
      else           fire_c[b] = 1'b0;
    end
  end

  always_comb begin
    pop     = (level_q != '0) && evt_ready_i;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NUM_CHK; k++) begin
      if (!gnt_vld && pend_q[(int'(rr_q) + k) % NUM_CHK]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDW'((int'(rr_q) + k) % NUM_CHK);
      end
    end
    push     = gnt_vld && ((level_q != LW'(FIFO_DEPTH)) || pop);
    push_rec = {gnt_idx, ptype_q[gnt_idx], pts_q[gnt_idx]};
    rr_d     = rr_q;
    if (push) rr_d = (gnt_idx == IDW'(NUM_CHK - 1)) ? '0 : gnt_idx + 1'b1;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // A fire on the checker being granted this cycle starts a fresh record.
  always_comb begin
    pend_d    = pend_q;
    ptype_d   = ptype_q;
    pts_d     = pts_q;
    fail_inc  = '0;
    xchk_inc  = '0;
    cover_inc = '0;
    coal_inc  = '0;
    for (int i = 0; i < NUM_CHK; i++) begin
      if (enable_i && (fire_c[3*i +: 3] != 3'b000)) begin
        if (!pend_q[i] || (push && (gnt_idx == IDW'(i)))) begin
          pend_d[i]  = 1'b1;
          ptype_d[i] = fire_c[3*i +: 3];
          pts_d[i]   = ts_q;
        end else begin
          ptype_d[i] = ptype_q[i] | fire_c[3*i +: 3];
          coal_inc   = coal_inc + 1'b1;
        end
      end else if (push && (gnt_idx == IDW'(i))) begin
        pend_d[i] = 1'b0;
      end
      if (enable_i) begin
        fail_inc  = fail_inc  + IW'(fire_c[3*i]);
        xchk_inc  = xchk_inc  + IW'(fire_c[3*i+1]);
        cover_inc = cover_inc + IW'(fire_c[3*i+2]);
      end
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      ts_q    <= '0;
      pend_q  <= '0;
      rr_q    <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      for (int i = 0; i < NUM_CHK; i++) begin
        ptype_q[i] <= '0;
        pts_q[i]   <= '0;
      end
      for (int j = 0; j < FIFO_DEPTH; j++) mem_q[j] <= '0;
    end else begin
      ts_q    <= ts_q + 1'b1;
      pend_q  <= pend_d;
      rr_q    <= rr_d;
      level_q <= level_d;
      for (int i = 0; i < NUM_CHK; i++) begin
        ptype_q[i] <= ptype_d[i];
        pts_q[i]   <= pts_d[i];
      end
      if (push) begin
        mem_q[wr_q] <= push_rec;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      fail_q      <= '0;
      xchk_q      <= '0;
      cover_q     <= '0;
      coal_q      <= '0;
      fail_seen_q <= 1'b0;
    end else if (clear_i) begin
      fail_q      <= '0;
      xchk_q      <= '0;
      cover_q     <= '0;
      coal_q      <= '0;
      fail_seen_q <= 1'b0;
    end else begin
      fail_q      <= sat_add(fail_q, fail_inc);
      xchk_q      <= sat_add(xchk_q, xchk_inc);
      cover_q     <= sat_add(cover_q, cover_inc);
      coal_q      <= sat_add(coal_q, coal_inc);
      fail_seen_q <= fail_seen_q | (fail_inc != '0);
    end
  end

  // When empty, the slot behind the read pointer still holds the last popped record.
  assign head         = (level_q != '0) ? mem_q[rd_q] : mem_q[rd_q - 1'b1];
  assign evt_valid_o  = (level_q != '0);
  assign evt_id_o     = head[REC_W-1 -: IDW];
  assign evt_type_o   = head[TS_W +: 3];
  assign evt_ts_o     = head[TS_W-1:0];
  assign fail_cnt_o   = fail_q;
  assign xchk_cnt_o   = xchk_q;
  assign cover_cnt_o  = cover_q;
  assign coal_cnt_o   = coal_q;
  assign fail_seen_o  = fail_seen_q;
  assign fifo_level_o = level_q;

endmodule

// File: tb/tb_ovl_fire_collector.sv
// Bench for ovl_fire_collector: directed scenarios plus a randomized run, all
// compared against a record-queue reference model of the collector.
module tb_ovl_fire_collector;
  localparam int N  = 4;
  localparam int TSW = 8;
  localparam int CW = 4;
  localparam int D  = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           en = 1'b0;
  logic           clr = 1'b0;
  logic           rdy = 1'b0;
  logic [3*N-1:0] fire = '0;
  logic           evt_valid;
  logic [1:0]     evt_id;
  logic [2:0]     evt_type;
  logic [TSW-1:0] evt_ts;
  logic [CW-1:0]  fail_cnt, xchk_cnt, cover_cnt, coal_cnt;
  logic           fail_seen;
  logic [3:0]     fifo_level;

  always #5 clk = ~clk;

  ovl_fire_collector #(.NUM_CHK(N), .TS_W(TSW), .CNT_W(CW), .FIFO_DEPTH(D)) dut (
    .clock_i(clk), .reset_ni(rst_n), .enable_i(en), .clear_i(clr), .fire_i(fire),
    .evt_valid_o(evt_valid), .evt_ready_i(rdy), .evt_id_o(evt_id), .evt_type_o(evt_type),
    .evt_ts_o(evt_ts), .fail_cnt_o(fail_cnt), .xchk_cnt_o(xchk_cnt), .cover_cnt_o(cover_cnt),
    .coal_cnt_o(coal_cnt), .fail_seen_o(fail_seen), .fifo_level_o(fifo_level)
  );

  int n_checks = 0;
  int n_pass = 0;

  // Reference model: per-checker open record, a queue of queued records {id,type,ts}.
  bit             m_pend  [N];
  logic [2:0]     m_ptype [N];
  logic [TSW-1:0] m_pts   [N];
  int             m_rr;
  logic [TSW-1:0] m_ts;
  logic [12:0]    mq[$];
  logic [12:0]    m_last;
  int             m_fail, m_xchk, m_cov, m_coal;
  bit             m_seen;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 0; m_ptype[i] = '0; m_pts[i] = '0;
    end
    mq.delete();
    m_last = '0; m_rr = 0; m_ts = '0;
    m_fail = 0; m_xchk = 0; m_cov = 0; m_coal = 0; m_seen = 0;
  endtask

  task automatic model_step();
    int g, fc, xc, cc, co;
    bit pop, can;
    logic [2:0] s;
    pop = (mq.size() != 0) && (rdy === 1'b1);
    can = (mq.size() < D) || pop;
    g = -1;
    if (can)
      for (int k = 0; k < N; k++)
        if (g < 0 && m_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
    if (pop) m_last = mq.pop_front();
    if (g >= 0) begin
      mq.push_back({2'(g), m_ptype[g], m_pts[g]});
      m_rr = (g + 1) % N;
    end
    fc = 0; xc = 0; cc = 0; co = 0;
    for (int i = 0; i < N; i++) begin
      s = fire[3*i +: 3];
      if (en && s != 3'b000) begin
        fc += int'(s[0]); xc += int'(s[1]); cc += int'(s[2]);
        if (!m_pend[i] || i == g) begin
          m_pend[i] = 1; m_ptype[i] = s; m_pts[i] = m_ts;
        end else begin
          m_ptype[i] |= s; co++;
        end
      end else if (i == g) begin
        m_pend[i] = 0;
      end
    end
    if (clr) begin
      m_fail = 0; m_xchk = 0; m_cov = 0; m_coal = 0; m_seen = 0;
    end else begin
      m_fail = (m_fail + fc > CMAX) ? CMAX : m_fail + fc;
      m_xchk = (m_xchk + xc > CMAX) ? CMAX : m_xchk + xc;
      m_cov  = (m_cov  + cc > CMAX) ? CMAX : m_cov  + cc;
      m_coal = (m_coal + co > CMAX) ? CMAX : m_coal + co;
      if (fc > 0) m_seen = 1;
    end
    m_ts = m_ts + 1'b1;
  endtask

  function automatic logic [17:0] exp_evt();
    logic [12:0] h;
    h = (mq.size() != 0) ? mq[0] : m_last;
    return {mq.size() != 0, h, 4'(mq.size())};
  endfunction
  function automatic logic [17:0] got_evt();
    return {evt_valid, evt_id, evt_type, evt_ts, fifo_level};
  endfunction
  function automatic logic [16:0] exp_st();
    return {4'(m_fail), 4'(m_xchk), 4'(m_cov), 4'(m_coal), m_seen};
  endfunction
  function automatic logic [16:0] got_st();
    return {fail_cnt, xchk_cnt, cover_cnt, coal_cnt, fail_seen};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic apply_reset();
    en = 1'b0; clr = 1'b0; rdy = 1'b0; fire = '0;
    rst_n = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    n_checks++;
    if (got_evt() !== 18'd0) $display("FAIL reset_evt got=%h exp=0", got_evt());
    else n_pass++;
    n_checks++;
    if (got_st() !== 17'd0) $display("FAIL reset_stats got=%h exp=0", got_st());
    else n_pass++;
  endtask

  task automatic test_single();
    apply_reset();
    en = 1'b1; rdy = 1'b1;
    repeat (5) tick();
    fire = 12'b000_000_001_000;
    tick();
    fire = '0;
    tick();
    n_checks++;
    if ({evt_valid, evt_id, evt_type, evt_ts} !== {1'b1, 2'd1, 3'b001, 8'd5})
      $display("FAIL single_rec got=%b_%0d_%b_%0d exp=1_1_001_5", evt_valid, evt_id, evt_type, evt_ts);
    else n_pass++;
    n_checks++;
    if (got_evt() !== exp_evt()) $display("FAIL single_model got=%h exp=%h", got_evt(), exp_evt());
    else n_pass++;
    tick();
    n_checks++;
    if ({evt_valid, fifo_level, fail_cnt, fail_seen} !== {1'b0, 4'd0, 4'd1, 1'b1})
      $display("FAIL single_after got=%b_%0d_%0d_%b exp=0_0_1_1", evt_valid, fifo_level, fail_cnt, fail_seen);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int ids[3] = '{0, 2, 3};
    logic [TSW-1:0] cap;
    apply_reset();
    en = 1'b1; rdy = 1'b1;
    tick();
    fire = 12'b001_001_000_001;
    cap = m_ts;
    tick();
    fire = '0;
    tick();
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({evt_valid, evt_id, evt_ts} !== {1'b1, 2'(ids[k]), cap})
        $display("FAIL b2b_rec%0d got=%b_%0d_%0d exp=1_%0d_%0d", k, evt_valid, evt_id, evt_ts, ids[k], cap);
      else n_pass++;
      n_checks++;
      if (got_evt() !== exp_evt()) $display("FAIL b2b_model%0d got=%h exp=%h", k, got_evt(), exp_evt());
      else n_pass++;
      tick();
    end
    n_checks++;
    if ({evt_valid, fail_cnt} !== {1'b0, 4'd3})
      $display("FAIL b2b_end got=%b_%0d exp=0_3", evt_valid, fail_cnt);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int popped = 0;
    apply_reset();
    en = 1'b1; rdy = 1'b0;
    fire = 12'h001;
    for (int k = 0; k < 20; k++) begin
      tick();
      n_checks++;
      if ({got_evt(), got_st()} !== {exp_evt(), exp_st()})
        $display("FAIL bp_fill%0d got=%h exp=%h", k, {got_evt(), got_st()}, {exp_evt(), exp_st()});
      else n_pass++;
    end
    fire = '0;
    n_checks++;
    if ({fifo_level, coal_cnt, fail_cnt} !== {4'd8, 4'd11, 4'd15})
      $display("FAIL bp_full got=%0d_%0d_%0d exp=8_11_15", fifo_level, coal_cnt, fail_cnt);
    else n_pass++;
    rdy = 1'b1;
    for (int k = 0; k < 15; k++) begin
      if (evt_valid === 1'b1) popped++;
      tick();
      n_checks++;
      if (got_evt() !== exp_evt()) $display("FAIL bp_drain%0d got=%h exp=%h", k, got_evt(), exp_evt());
      else n_pass++;
    end
    n_checks++;
    if (popped !== 9 || fifo_level !== 4'd0)
      $display("FAIL bp_count popped=%0d level=%0d exp=9_0", popped, fifo_level);
    else n_pass++;
  endtask

  task automatic test_coalesce();
    logic [TSW-1:0] cap;
    int found = 0;
    apply_reset();
    en = 1'b1; rdy = 1'b0;
    fire = 12'h008;
    repeat (9) tick();
    fire = '0; clr = 1'b1;
    tick();
    clr = 1'b0;
    n_checks++;
    if (fifo_level !== 4'd8) $display("FAIL coal_full got=%0d exp=8", fifo_level);
    else n_pass++;
    fire = 12'h100; cap = m_ts;
    tick();
    fire = '0;
    tick(); tick();
    fire = 12'h080;
    tick();
    fire = '0;
    n_checks++;
    if ({cover_cnt, xchk_cnt, coal_cnt} !== {4'd1, 4'd1, 4'd1})
      $display("FAIL coal_stats got=%0d_%0d_%0d exp=1_1_1", cover_cnt, xchk_cnt, coal_cnt);
    else n_pass++;
    n_checks++;
    if (got_st() !== exp_st()) $display("FAIL coal_model got=%h exp=%h", got_st(), exp_st());
    else n_pass++;
    rdy = 1'b1;
    for (int k = 0; k < 15; k++) begin
      if (evt_valid === 1'b1 && evt_id === 2'd2) begin
        found++;
        n_checks++;
        if ({evt_type, evt_ts} !== {3'b110, cap})
          $display("FAIL coal_rec got=%b_%0d exp=110_%0d", evt_type, evt_ts, cap);
        else n_pass++;
      end
      tick();
      n_checks++;
      if (got_evt() !== exp_evt()) $display("FAIL coal_drain%0d got=%h exp=%h", k, got_evt(), exp_evt());
      else n_pass++;
    end
    n_checks++;
    if (found !== 1) $display("FAIL coal_found got=%0d exp=1", found);
    else n_pass++;
  endtask

  task automatic test_saturation();
    apply_reset();
    en = 1'b1; rdy = 1'b1;
    fire = 12'h001;
    repeat (20) tick();
    n_checks++;
    if ({fail_cnt, fail_seen} !== {4'd15, 1'b1})
      $display("FAIL sat_cnt got=%0d_%b exp=15_1", fail_cnt, fail_seen);
    else n_pass++;
    clr = 1'b1;
    tick();
    n_checks++;
    if ({fail_cnt, fail_seen} !== {4'd0, 1'b0})
      $display("FAIL sat_clear got=%0d_%b exp=0_0", fail_cnt, fail_seen);
    else n_pass++;
    n_checks++;
    if (got_st() !== exp_st()) $display("FAIL sat_model got=%h exp=%h", got_st(), exp_st());
    else n_pass++;
    clr = 1'b0; fire = '0;
    repeat (4) tick();
  endtask

  task automatic test_disable_and_reset();
    en = 1'b0; fire = '1;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (evt_valid !== 1'b0 || {got_evt(), got_st()} !== {exp_evt(), exp_st()})
        $display("FAIL dis%0d got=%h exp=%h", k, {got_evt(), got_st()}, {exp_evt(), exp_st()});
      else n_pass++;
    end
    en = 1'b1; rdy = 1'b0;
    fire = 12'h049;
    tick();
    fire = '0;
    repeat (4) tick();
    n_checks++;
    if (fifo_level !== 4'd3) $display("FAIL dis_level got=%0d exp=3", fifo_level);
    else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({evt_valid, fifo_level, fail_cnt} !== {1'b0, 4'd0, 4'd0})
      $display("FAIL async_reset got=%b_%0d_%0d exp=0_0_0", evt_valid, fifo_level, fail_cnt);
    else n_pass++;
    model_reset();
    #1 rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [3*N-1:0] f;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      f = '0;
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 3) == 0) f[3*i +: 3] = 3'($urandom_range(1, 7));
      fire = f;
      en   = ($urandom_range(0, 9) != 0);
      clr  = ($urandom_range(0, 29) == 0);
      rdy  = (((c / 25) % 3) == 2) ? 1'b0 : ($urandom_range(0, 3) != 0);
      tick();
      n_checks++;
      if (got_evt() !== exp_evt()) $display("FAIL rand_evt c=%0d got=%h exp=%h", c, got_evt(), exp_evt());
      else n_pass++;
      n_checks++;
      if (got_st() !== exp_st()) $display("FAIL rand_stats c=%0d got=%h exp=%h", c, got_st(), exp_st());
      else n_pass++;
    end
    fire = '0; en = 1'b0; clr = 1'b0;
  endtask

  initial begin
    model_reset();
    #12 rst_n = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_coalesce();
    test_saturation();
    test_disable_and_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ovl_fire_collector.md
Name: ovl_fire_collector

Overview:
- Sits directly downstream of a bank of OVL checkers (ovl_delta and siblings). Consumes their 3-bit fire outputs and timestamps each firing.
- Queues one event record per checker firing for a testbench or monitor drain port, using a valid/ready handshake.
- Keeps saturating per-type statistics and a sticky failure flag so directed OVL tests can assert pass/fail without scanning waveforms.

Parameters:
NUM_CHK, 4, number of checkers; must be 2 or more.
TS_W, 32, timestamp counter width.
CNT_W, 16, statistics counter width.
FIFO_DEPTH, 8, event FIFO depth; must be a power of 2, 2 or more.

Ports:
clock  in  1  sampling clock; all logic on posedge.
reset  in  1  asynchronous, active-low reset.
enable  in  1  1 = capture fires; 0 = ignore fires while drain and timestamp continue.
clear  in  1  synchronous clear of statistics and fail_seen; FIFO and pending state are untouched.
fire  in  3*NUM_CHK  checker i occupies fire[3i+2:3i]; bit0 = assertion fail, bit1 = X-check, bit2 = cover.
evt_valid  out  1  a record is available at the FIFO head.
evt_ready  in  1  consumer accepts the head record.
evt_id  out  $clog2(NUM_CHK)  checker index of the head record.
evt_type  out  3  OR of fire bits accumulated for that record.
evt_ts  out  TS_W  timestamp of the first fire in the record.
fail_cnt, xchk_cnt, cover_cnt  out  CNT_W each  saturating totals of bit0, bit1 and bit2 occurrences.
coal_cnt  out  CNT_W  saturating count of fires merged into an already-pending record.
fail_seen  out  1  sticky; set by any captured bit0.
fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async assert, sync deassert handled upstream) clears the following to 0:
  - outputs, counters, timestamp, pending flags, FIFO pointers;
  - round-robin pointer, so checker 0 has highest priority.
- Timestamp ts: free-running, +1 every clock, wraps at 2^TS_W-1 to 0.
- Capture happens each posedge with enable=1, for each checker i with fire slice nonzero:
  - If pend[i]=0, or checker i is granted this cycle: set pend[i]=1, ptype[i]=slice, pts[i]=ts. This opens a fresh record.
  - Else: ptype[i] |= slice, coal_cnt+1 (saturating). Merged fires from several checkers in one cycle add their count.
- Arbiter:
  - Each cycle, grant the lowest pending index at or above the rr pointer (modulo NUM_CHK).
  - A grant requires FIFO not full, or full with a pop this cycle.
  - On grant: push {i, ptype[i], pts[i]}, clear pend[i] unless re-set by the capture rule, then rr pointer = i+1 mod NUM_CHK.
  - At most one push per cycle.
- Latency: fire sampled at edge N gives pend at N, push at edge N+1, evt_valid high after N+1 (minimum 2 cycles). No fire is ever dropped; back-pressure only coalesces.
- FIFO:
  - Pop when evt_valid && evt_ready.
  - evt_* outputs are stable while evt_valid && !evt_ready.
  - Simultaneous push and pop when full or empty are legal; level is unchanged when full.
  - Empty gives evt_valid=0, with evt_* holding their last value.
- Statistics:
  - Each counter adds the popcount of its bit across all checkers whenever enable=1, saturating at all-ones; no wrap.
  - fail_seen is set with the first captured bit0.
  - clear=1 zeroes fail_cnt, xchk_cnt, cover_cnt, coal_cnt and fail_seen.
  - clear has priority over a same-cycle increment: the result is 0.
- enable=0: no capture and no statistics updates. Pending records are still granted and drained.
- X on fire while enable=1 is treated as 0 for capture. The OVL X-check bit reports it separately.
- Reset mid-operation discards pending records and FIFO contents immediately.

Test Plan:
- Reset, enable=1, checker 1 fire=3'b001 for one cycle at ts=5, evt_ready=1 -> evt_valid 2 cycles later with id=1, type=001, ts=5; fail_cnt=1, fail_seen=1, fifo_level back to 0.
- Checkers 0, 2 and 3 fire bit0 in the same cycle, evt_ready=1 -> three records in order id 0, 2, 3 on consecutive cycles, identical ts; fail_cnt=3.
- evt_ready=0; checker 0 fires every cycle for 20 cycles, NUM_CHK=4, FIFO_DEPTH=8 -> records drain as one pushed per cycle:
  - FIFO fills to 8, then holds;
  - checker 0 stays pending; further fires coalesce into coal_cnt;
  - no record is lost after evt_ready=1.
- Checker 2 fires 3'b100, then 3'b010 three cycles later while the FIFO is full -> single record type=110 with the first ts; cover_cnt=1, xchk_cnt=1, coal_cnt=1.
- CNT_W=4, 20 fail fires -> fail_cnt saturates at 15. Then clear=1 together with a fire -> fail_cnt=0, fail_seen=0.
- enable=0 with fire=all ones for 5 cycles -> no records and counters unchanged. Assert reset while fifo_level=3 -> evt_valid=0, fifo_level=0 asynchronously.
